instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the program counter and drives the word address into the combinational instruction memory. It registers the returned word plus PC+4 into the IF/ID pipeline register. It also handles stall, flush, taken-branch/jump redirect, and a halt condition that freezes fetch at end of program.

## Interface
- RESET_PC, 32'h0000_0000, byte address loaded into PC on reset
- HALT_WORD, 32'hFC00_0000, instruction encoding (opcode 6'h3F) that ends fetch

- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- FetchAddress  out  32  word index to instruction memory Address port; equals {2'b00, PC[31:2]}
- FetchInstruction  in  32  instruction word returned combinationally by the memory
- Stall  in  1  hazard unit: hold PC and IF/ID
- Flush  in  1  replace IF/ID contents with a bubble
- BranchTaken  in  1  EX-stage redirect request
- BranchTarget  in  32  byte redirect address; bits [1:0] ignored (forced 0)
- PC  out  32  current program counter (byte address)
- IFID_Instruction  out  32  registered instruction to decode
- IFID_PCPlus4  out  32  registered PC+4 of that instruction
- IFID_Valid  out  1  IF/ID holds a real instruction (0 = bubble)
- Halted  out  1  fetch frozen on HALT_WORD

## Operation
- Reset (Reset=0, async): PC=RESET_PC, IFID_Instruction=0, IFID_PCPlus4=0, IFID_Valid=0, Halted=0, state=START.
- States: START, RUN, HALT.
- START: lasts exactly one cycle after Reset deasserts. PC holds. IF/ID is loaded with a bubble. Next state is RUN. BranchTaken, Stall and Flush are ignored.
- RUN, per-edge priority (highest first):
  - BranchTaken: PC<=BranchTarget&~3; IF/ID<=bubble (wrong-path word discarded), regardless of Stall/Flush.
  - Flush (no BranchTaken): IF/ID<=bubble. PC<=PC+4 unless Stall, in which case PC holds.
  - Stall: PC and all IF/ID outputs hold.
  - Otherwise: IFID_Instruction<=FetchInstruction, IFID_PCPlus4<=PC+4, IFID_Valid<=1, PC<=PC+4.
- Halt detection: only in the RUN "otherwise" case with FetchInstruction==HALT_WORD.
  - The halt word is registered into IF/ID as valid (it propagates as a nop downstream).
  - PC does not advance.
  - State becomes HALT and Halted<=1.
- HALT:
  - PC holds and IF/ID is loaded with bubbles each cycle; Stall and Flush have no further effect.
  - BranchTaken (an older in-flight branch proving the halt was wrong-path) sets PC<=target, Halted<=0, state=RUN, IF/ID<=bubble.
- Bubble: IFID_Instruction=0 (sll $0 nop), IFID_PCPlus4=0, IFID_Valid=0.
- Arithmetic: PC+4 is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0 with no flag.

## Timing
- FetchAddress is combinational from the PC register only; no path from FetchInstruction to FetchAddress.
- Fetch latency: PC value at cycle n produces IF/ID of that word after edge n+1 (1 cycle).
- Redirect: BranchTaken high in cycle n gives PC=target in n+1 and the target's IF/ID valid in n+2. Exactly one bubble is inserted by this block.
- First valid IF/ID after reset release: PC=RESET_PC is fetched in cycle 1 (after START) and is valid after the second rising edge.
- Stall held k cycles: IF/ID and PC unchanged for k edges; sequential progress resumes on the first edge with Stall=0.
- Reset asserted mid-stream: all outputs take reset values immediately, without waiting for Clk.

## Test plan
- Reset/sequential: RESET_PC=0, memory word i = i*4. Release Reset → FetchAddress 0,1,2,3…; IFID_Instruction 0,4,8 with IFID_PCPlus4 4,8,12 and IFID_Valid=1 from the 2nd edge onward.
- Stall: assert Stall for 3 cycles while PC=0x10 → PC stays 0x10, IF/ID frozen on the 0x0C entry. Deassert → next IF/ID is the word at index 4 with PCPlus4=0x14.
- Branch beats stall/flush: at PC=0x20 assert BranchTaken=1, Stall=1, Flush=1, BranchTarget=0x43 → PC=0x40, one bubble (Valid=0), then IFID_PCPlus4=0x44.
- Flush without stall: Flush at PC=0x08 → IF/ID bubble, PC=0x0C next cycle, no word lost beyond the flushed one.
- Halt: place HALT_WORD at index 5 → IF/ID shows HALT_WORD valid, then Halted=1 with PC frozen at 0x14 and bubbles thereafter. BranchTaken to 0x00 while halted → Halted=0 and fetch resumes at index 0.
- Wrap and async reset: force PC=0xFFFF_FFFC via BranchTaken → next PC=0, IFID_PCPlus4=0. Assert Reset mid-cycle → outputs zero and PC=RESET_PC before the next edge.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Purpose : MIPS IF stage -- owns the PC, addresses instruction memory, fills the IF/ID register.
// Latency : 1 cycle from PC to IF/ID; a taken redirect costs exactly one bubble.
// Backpres: i_Stall freezes PC and IF/ID; i_Flush bubbles IF/ID; HALT_WORD freezes fetch until a redirect.
//
// Ports:
//   i_Clk, i_Reset (async, active low)
//   o_FetchAddress      word index {2'b00, PC[31:2]} to instruction memory
//   i_FetchInstruction  combinational instruction word from memory
//   i_Stall, i_Flush    hazard-unit controls
//   i_BranchTaken, i_BranchTarget  EX-stage redirect (target bits [1:0] forced to 0)
//   o_PC                current program counter (byte address)
//   o_IFID_Instruction, o_IFID_PCPlus4, o_IFID_Valid  IF/ID pipeline register
//   o_Halted            fetch frozen on HALT_WORD
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD = 32'hFC00_0000
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    output logic [31:0] o_FetchAddress,
    input  logic [31:0] i_FetchInstruction,
    input  logic        i_Stall,
    input  logic        i_Flush,
    input  logic        i_BranchTaken,
    input  logic [31:0] i_BranchTarget,
    output logic [31:0] o_PC,
    output logic [31:0] o_IFID_Instruction,
    output logic [31:0] o_IFID_PCPlus4,
    output logic        o_IFID_Valid,
    output logic        o_Halted
);

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_ifid_instr, w_ifid_instr_nxt;
    logic [31:0] r_ifid_pcp4, w_ifid_pcp4_nxt;
    logic        r_ifid_vld, w_ifid_vld_nxt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;

    // Modulo-2^32 increment: 32'hFFFF_FFFC wraps to 0 silently.
    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_target   = {i_BranchTarget[31:2], 2'b00};

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            r_state      <= START;
            r_pc         <= RESET_PC;
            r_ifid_instr <= 32'd0;
            r_ifid_pcp4  <= 32'd0;
            r_ifid_vld   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_pcp4  <= w_ifid_pcp4_nxt;
            r_ifid_vld   <= w_ifid_vld_nxt;
        end
    end

    always_comb begin
        // Default: hold everything (this is also the plain-stall behaviour).
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_pcp4_nxt  = r_ifid_pcp4;
        w_ifid_vld_nxt   = r_ifid_vld;

        case (r_state)
            START: begin
                // One settling cycle after reset: PC holds, IF/ID gets a bubble,
                // and all control inputs are ignored.
                w_ifid_instr_nxt = 32'd0;
                w_ifid_pcp4_nxt  = 32'd0;
                w_ifid_vld_nxt   = 1'b0;
                w_state_nxt      = RUN;
            end
            RUN: begin
                if (i_BranchTaken) begin
                    // Redirect wins over stall/flush; the wrong-path word is dropped.
                    w_pc_nxt         = w_target;
                    w_ifid_instr_nxt = 32'd0;
                    w_ifid_pcp4_nxt  = 32'd0;
                    w_ifid_vld_nxt   = 1'b0;
                end else if (i_Flush) begin
                    w_ifid_instr_nxt = 32'd0;
                    w_ifid_pcp4_nxt  = 32'd0;
                    w_ifid_vld_nxt   = 1'b0;
                    if (!i_Stall) begin
                        w_pc_nxt = w_pc_plus4;
                    end
                end else if (!i_Stall) begin
                    w_ifid_instr_nxt = i_FetchInstruction;
                    w_ifid_pcp4_nxt  = w_pc_plus4;
                    w_ifid_vld_nxt   = 1'b1;
                    // The halt word itself goes downstream as a valid nop, but
                    // the PC stays parked on it.
                    if (i_FetchInstruction == HALT_WORD) begin
                        w_state_nxt = HALT;
                    end else begin
                        w_pc_nxt = w_pc_plus4;
                    end
                end
            end
            HALT: begin
                w_ifid_instr_nxt = 32'd0;
                w_ifid_pcp4_nxt  = 32'd0;
                w_ifid_vld_nxt   = 1'b0;
                // An older branch resolving late means the halt was wrong-path.
                if (i_BranchTaken) begin
                    w_pc_nxt    = w_target;
                    w_state_nxt = RUN;
                end
            end
            default: begin
                w_state_nxt = START;
            end
        endcase
    end

    assign o_FetchAddress     = {2'b00, r_pc[31:2]};
    assign o_PC               = r_pc;
    assign o_IFID_Instruction = r_ifid_instr;
    assign o_IFID_PCPlus4     = r_ifid_pcp4;
    assign o_IFID_Valid       = r_ifid_vld;
    assign o_Halted           = (r_state == HALT);

endmodule
